shift_reg_universal: RTL and testbench

Parametrised universal shift register, the successor to the team's fixed-width SISO shifter. Supports hold, bidirectional logical shift, arithmetic shift, rotate, parallel load and clear, with serial taps at both ends. Adds a burst engine: one start command performs K shift/rotate steps autonomously, with busy/done status. Used by serializers and bit-manipulation datapaths.

---
 rtl/shift_reg_universal_if.sv | 29 ++
 rtl/shift_reg_universal.sv | 118 +++++++++++
 tb/tb_shift_reg_universal.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/shift_reg_universal_if.sv
// Control and data bundle for shift_reg_universal.
// The master drives the commands and the slave (the shifter) returns its state.
interface shift_reg_universal_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 4
);
    logic          en;
    logic [2:0]    mode;
    logic          s_in_r;
    logic          s_in_l;
    logic [N-1:0]  d_in;
    logic          start;
    logic [CW-1:0] count;
    logic [N-1:0]  q;
    logic          s_out_r;
    logic          s_out_l;
    logic          busy;
    logic          done;

    modport master (
        output en, mode, s_in_r, s_in_l, d_in, start, count,
        input  q, s_out_r, s_out_l, busy, done
    );

    modport slave (
        input  en, mode, s_in_r, s_in_l, d_in, start, count,
        output q, s_out_r, s_out_l, busy, done
    );
endinterface

// File: rtl/shift_reg_universal.sv
// Universal N-bit shift register: single-step ops in IDLE, plus a burst engine
// that repeats one shift/rotate op K times with busy/done status.
module shift_reg_universal #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_reg_universal_if.slave  bus
);
    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [2:0]    op_q, op_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next register value for one application of op.
    function automatic logic [N-1:0] apply_op(input logic [2:0] op,
                                              input logic [N-1:0] cur,
                                              input logic sin_r,
                                              input logic sin_l,
                                              input logic [N-1:0] din);
        logic [N-1:0] r;
        r = cur;
        case (op)
            M_HOLD: r = cur;
            M_SHR:  r = {sin_r, cur[N-1:1]};
            M_SHL:  r = {cur[N-2:0], sin_l};
            M_LOAD: r = din;
            M_ROR:  r = {cur[0], cur[N-1:1]};
            M_ROL:  r = {cur[N-2:0], cur[N-1]};
            M_ASR:  r = {cur[N-1], cur[N-1:1]};
            M_CLR:  r = '0;
            default: r = cur;
        endcase
        return r;
    endfunction

    function automatic logic is_burst_op(input logic [2:0] op);
        return (op == M_SHR) || (op == M_SHL) || (op == M_ROR) ||
               (op == M_ROL) || (op == M_ASR);
    endfunction

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        op_d    = op_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // start only counts for repeatable ops; load/clear/hold fall back to en
                if (bus.start && is_burst_op(bus.mode)) begin
                    if (bus.count != '0) begin
                        state_d = RUN;
                        op_d    = bus.mode;
                        rem_d   = bus.count;
                        busy_d  = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                    end
                end else if (bus.en) begin
                    q_d = apply_op(bus.mode, q_q, bus.s_in_r, bus.s_in_l, bus.d_in);
                end
            end
            RUN: begin
                q_d   = apply_op(op_q, q_q, bus.s_in_r, bus.s_in_l, bus.d_in);
                rem_d = rem_q - CW'(1);
                if (rem_q == CW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            op_q    <= M_HOLD;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.s_out_r = q_q[0];
    assign bus.s_out_l = q_q[N-1];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed test of shift_reg_universal: single-step ops, bursts, ignored
// inputs during a burst, reset abort and back-to-back bursts.
module tb_shift_reg_universal;
    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    shift_reg_universal_if #(.N(8), .CW(4)) bus ();

    shift_reg_universal #(.N(8), .CW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        chk({tag, ".q"}, 32'(bus.q), 32'(eq));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(eb));
        chk({tag, ".done"}, 32'(bus.done), 32'(ed));
    endtask

    task automatic load(input logic [7:0] v);
        bus.en = 1'b1; bus.start = 1'b0; bus.mode = 3'b011; bus.d_in = v;
        step();
        bus.en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.en = 1'b1; bus.mode = 3'b011; bus.d_in = 8'hFF;
        bus.s_in_r = 1'b0; bus.s_in_l = 1'b0; bus.start = 1'b0; bus.count = 4'd0;
        step(); step();
        chk_st("reset", 8'h00, 1'b0, 1'b0);
        chk("reset.s_out_r", 32'(bus.s_out_r), 32'd0);
        chk("reset.s_out_l", 32'(bus.s_out_l), 32'd0);
        reset = 1'b0;

        // single-step operations
        load(8'hA5);
        chk("load", 32'(bus.q), 32'h A5);
        bus.en = 1'b1; bus.mode = 3'b001; bus.s_in_r = 1'b1;
        step();
        chk("shr.q", 32'(bus.q), 32'h D2);
        chk("shr.s_out_r", 32'(bus.s_out_r), 32'd0);
        chk("shr.s_out_l", 32'(bus.s_out_l), 32'd1);
        bus.mode = 3'b010; bus.s_in_l = 1'b1;
        step();
        chk("shl.q", 32'(bus.q), 32'h A5);
        bus.en = 1'b0; bus.mode = 3'b010;
        step();
        chk("en0_hold", 32'(bus.q), 32'h A5);
        load(8'h80);
        bus.en = 1'b1; bus.mode = 3'b110;
        step();
        chk("asr1", 32'(bus.q), 32'h C0);
        step();
        chk("asr2", 32'(bus.q), 32'h E0);
        bus.mode = 3'b111;
        step();
        chk("clr", 32'(bus.q), 32'h00);
        bus.en = 1'b0;

        // burst rotate right by 3
        load(8'h81);
        bus.start = 1'b1; bus.mode = 3'b100; bus.count = 4'd3;
        step();
        chk_st("ror.accept", 8'h81, 1'b1, 1'b0);
        bus.start = 1'b0; bus.mode = 3'b000;
        step();
        chk_st("ror.1", 8'hC0, 1'b1, 1'b0);
        step();
        chk_st("ror.2", 8'h60, 1'b1, 1'b0);
        step();
        chk_st("ror.3", 8'h30, 1'b0, 1'b1);
        step();
        chk_st("ror.after", 8'h30, 1'b0, 1'b0);

        // burst rotate left by 9 wraps to a net rotate by 1
        load(8'h01);
        bus.start = 1'b1; bus.mode = 3'b101; bus.count = 4'd9;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk_st("rol9.step8", 8'h01, 1'b1, 1'b0);
        step();
        chk_st("rol9.end", 8'h02, 1'b0, 1'b1);

        // zero-count start: done pulse only
        bus.start = 1'b1; bus.mode = 3'b101; bus.count = 4'd0;
        step();
        chk_st("cnt0", 8'h02, 1'b0, 1'b1);
        bus.start = 1'b0;
        step();
        chk_st("cnt0.after", 8'h02, 1'b0, 1'b0);

        // inputs ignored while running a shift-left burst
        load(8'h0F);
        bus.start = 1'b1; bus.mode = 3'b010; bus.count = 4'd4; bus.s_in_l = 1'b0;
        step();
        bus.en = 1'b1; bus.mode = 3'b011; bus.d_in = 8'hAA;
        step();
        chk_st("ign.1", 8'h1E, 1'b1, 1'b0);
        step(); step();
        chk_st("ign.3", 8'h78, 1'b1, 1'b0);
        step();
        chk_st("ign.4", 8'hF0, 1'b0, 1'b1);
        // start with LOAD is not a burst; en makes it an ordinary load
        bus.start = 1'b1; bus.en = 1'b1; bus.mode = 3'b011; bus.d_in = 8'h3C;
        step();
        chk_st("start_load", 8'h3C, 1'b0, 1'b0);
        bus.start = 1'b0; bus.en = 1'b0;

        // reset aborts a burst without a done pulse
        bus.start = 1'b1; bus.mode = 3'b001; bus.count = 4'd6; bus.s_in_r = 1'b0;
        step();
        bus.start = 1'b0;
        step();
        chk_st("abort.2", 8'h1E, 1'b1, 1'b0);
        step();
        chk_st("abort.3", 8'h0F, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        chk_st("abort.rst", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk_st("abort.after", 8'h00, 1'b0, 1'b0);

        // new start accepted in the done cycle
        load(8'h81);
        bus.start = 1'b1; bus.mode = 3'b100; bus.count = 4'd1;
        step();
        chk_st("b2b.accept1", 8'h81, 1'b1, 1'b0);
        bus.count = 4'd2;
        step();
        chk_st("b2b.done1", 8'hC0, 1'b0, 1'b1);
        step();
        chk_st("b2b.accept2", 8'hC0, 1'b1, 1'b0);
        bus.start = 1'b0;
        step();
        chk_st("b2b.run", 8'h60, 1'b1, 1'b0);
        step();
        chk_st("b2b.done2", 8'h30, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
